// File: rtl/phys_free_list.sv
// phys_free_list: circular FIFO of free physical register indices between rename and commit.
// Define FREE_LIST_CHECK_EN to add an in-list bitmap that rejects duplicate enqueues.
module phys_free_list #(
    parameter int NUM_PHYS_REGS = 64,
    parameter int NUM_ARCH_REGS = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             deq_en,
    output logic [$clog2(NUM_PHYS_REGS)-1:0] deq_preg,
    output logic                             deq_valid,
    input  logic                             enq_en,
    input  logic [$clog2(NUM_PHYS_REGS)-1:0] enq_preg,
    input  logic                             flush,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(NUM_PHYS_REGS-NUM_ARCH_REGS):0] count,
    output logic                             err
);
    localparam int DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int PW    = $clog2(NUM_PHYS_REGS);
    localparam int IW    = $clog2(DEPTH);

    logic [PW-1:0] mem_q [DEPTH];
    logic [PW-1:0] mem_d [DEPTH];
    logic [IW:0]   head_q, head_d, tail_q, tail_d;
    logic          err_q, err_d;
    logic          enq_nz, deq_take, enq_ok, dup;

    assign empty     = head_q == tail_q;
    assign full      = (head_q[IW-1:0] == tail_q[IW-1:0]) && (head_q[IW] != tail_q[IW]);
    assign count     = tail_q - head_q;
    assign deq_valid = !empty;
    assign deq_preg  = mem_q[head_q[IW-1:0]];
    assign err       = err_q;

`ifdef FREE_LIST_CHECK_EN
    logic [NUM_PHYS_REGS-1:0] in_list_q, in_list_d;
    assign dup = in_list_q[enq_preg];
`else
    assign dup = 1'b0;
`endif

    // A dequeue frees the full slot in the same cycle, so a full list still accepts the enqueue.
    always_comb begin
        enq_nz   = enq_en && (enq_preg != '0);
        deq_take = deq_en && !empty && !flush;
        enq_ok   = enq_nz && !dup && (!full || deq_take);
        mem_d    = mem_q;
        if (enq_ok) mem_d[tail_q[IW-1:0]] = enq_preg;
        tail_d = tail_q + (IW+1)'(enq_ok);
        head_d = flush ? {~tail_d[IW], tail_d[IW-1:0]} : head_q + (IW+1)'(deq_take);
        err_d  = err_q || (deq_en && empty && !flush) || (enq_nz && (dup || (full && !deq_take)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= PW'(NUM_ARCH_REGS + i);
            head_q <= '0;
            tail_q <= {1'b1, {IW{1'b0}}};
            err_q  <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            err_q  <= err_d;
        end
    end

`ifdef FREE_LIST_CHECK_EN
    // After a flush every storage slot is valid, so the bitmap is exactly the set of stored indices.
    always_comb begin
        in_list_d = in_list_q;
        if (deq_take) in_list_d[deq_preg] = 1'b0;
        if (enq_ok) in_list_d[enq_preg] = 1'b1;
        if (flush) begin
            in_list_d = '0;
            for (int i = 0; i < DEPTH; i++) in_list_d[mem_d[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_list_q <= {{DEPTH{1'b1}}, {NUM_ARCH_REGS{1'b0}}};
        else in_list_q <= in_list_d;
    end
`endif
endmodule
